// File: rtl/spi_frame_master.sv
// Frames a one-cycle {cmd, tx_data} request into an SPI transaction on SS_n/MOSI
// and, for rd-data commands, captures the 8-bit MISO reply into rx_data.
module spi_frame_master #(
  parameter int BIT_DIV    = 1,
  parameter int TURNAROUND = 2,
  parameter int IDLE_GAP   = 1
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [2:0] fsm_state
);

  // Request handshake: start is taken on any rising edge where busy is low; the
  // request is latched and busy rises at that edge. Starts seen while busy is
  // high are dropped, never queued.

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_TURN    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_END     = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(BIT_DIV - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
  localparam logic [7:0] GAP_LAST  = 8'(IDLE_GAP - 2);

  state_t     state;
  logic [9:0] frame;
  logic [7:0] div_cnt;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       period_end;

  assign period_end = (div_cnt == DIV_LAST);
  assign fsm_state  = state;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state    <= ST_IDLE;
      frame    <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            frame   <= {cmd, tx_data};
            state   <= ST_SHIFT;
            busy    <= 1'b1;
            SS_n    <= 1'b0;
            MOSI    <= cmd[1];
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (period_end) begin
            div_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              bit_cnt <= '0;
              MOSI    <= 1'b0;
              if (frame[9:8] == 2'b11) begin
                state <= (TURNAROUND == 0) ? ST_CAPTURE : ST_TURN;
              end else begin
                state <= ST_END;
                SS_n  <= 1'b1;
                done  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              MOSI    <= frame[4'd8 - bit_cnt];
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        ST_TURN: begin
          if (period_end) begin
            div_cnt <= '0;
            if (bit_cnt == TURN_LAST) begin
              bit_cnt <= '0;
              state   <= ST_CAPTURE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        ST_CAPTURE: begin
          // MISO is taken on the edge closing each bit period; the eighth bit
          // goes straight into rx_data alongside done.
          if (period_end) begin
            div_cnt <= '0;
            shreg   <= {shreg[6:0], MISO};
            if (bit_cnt == 4'd7) begin
              bit_cnt  <= '0;
              state    <= ST_END;
              SS_n     <= 1'b1;
              done     <= 1'b1;
              rx_valid <= 1'b1;
              rx_data  <= {shreg[6:0], MISO};
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        ST_END: begin
          div_cnt <= '0;
          if (IDLE_GAP <= 1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= '0;
            state   <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          SS_n  <= 1'b1;
          MOSI  <= 1'b0;
        end
      endcase
    end
  end

endmodule
